// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic MAC array sequencer.
package systolic_pkg;

   typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_e;
   typedef enum logic [1:0] {TAG_NONE, TAG_W, TAG_ACT} tag_kind_e;

   localparam int unsigned ACT_BASE_DEF = 16;
   localparam int unsigned IDX_W        = 4;

endpackage

// File: rtl/systolic_rd_tag.sv
// One-stage tag register: remembers what the previous cycle's read was for, so the
// returning mem_rdata can be steered to the array.
module systolic_rd_tag
   import systolic_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr_i,
   input  tag_kind_e        kind_i,
   input  logic [IDX_W-1:0] idx_i,
   output tag_kind_e        kind_o,
   output logic [IDX_W-1:0] idx_o
);

   tag_kind_e        kind_q;
   logic [IDX_W-1:0] idx_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kind_q <= TAG_NONE;
         idx_q  <= '0;
      end else if (clr_i) begin
         kind_q <= TAG_NONE;
         idx_q  <= '0;
      end else begin
         kind_q <= kind_i;
         idx_q  <= idx_i;
      end
   end

   assign kind_o = kind_q;
   assign idx_o  = idx_q;

endmodule

// File: rtl/systolic_sequencer.sv
// Sequences weight loads, activation streaming and drain bubbles for the systolic array,
// sharing the register-file port with host writes (host always wins).
module systolic_sequencer
   import systolic_pkg::*;
#(
   parameter int unsigned ADDR_W   = 7,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ROWS     = 2,
   parameter int unsigned COLS     = 2,
   parameter int unsigned ACT_BASE = ACT_BASE_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [3:0]        k_len_i,
   input  logic              host_wr_i,
   output logic              mem_rd_en_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              arr_wload_o,
   output logic              arr_act_o,
   output logic [IDX_W-1:0]  arr_idx_o,
   output logic [DATA_W-1:0] arr_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   localparam int unsigned NumW   = ROWS * COLS;
   localparam int unsigned NumBub = ROWS + COLS - 1;

   state_e           state_q;
   logic [3:0]       k_q;
   logic [7:0]       cnt_q;
   logic [3:0]       i_q;
   logic [3:0]       r_q;
   logic             bubble_q;
   logic [IDX_W-1:0] bub_idx_q;
   logic             done_q;
   logic             err_q;

   tag_kind_e        tag_kind_d, tag_kind_q;
   logic [IDX_W-1:0] tag_idx_d, tag_idx_q;
   logic             tag_valid;

   // Read issue: combinational so the address goes out in the same cycle as the strobe.
   always_comb begin
      mem_rd_en_o = 1'b0;
      mem_addr_o  = '0;
      tag_kind_d  = TAG_NONE;
      tag_idx_d   = '0;
      case (state_q)
         LOAD_W: begin
            if (!host_wr_i) begin
               mem_rd_en_o = 1'b1;
               mem_addr_o  = ADDR_W'(cnt_q);
               tag_kind_d  = TAG_W;
               tag_idx_d   = IDX_W'(cnt_q);
            end
         end
         STREAM: begin
            if (!host_wr_i) begin
               mem_rd_en_o = 1'b1;
               mem_addr_o  = ADDR_W'(ACT_BASE + 32'(i_q) * ROWS + 32'(r_q));
               tag_kind_d  = TAG_ACT;
               tag_idx_d   = IDX_W'(r_q);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         k_q       <= '0;
         cnt_q     <= '0;
         i_q       <= '0;
         r_q       <= '0;
         bubble_q  <= 1'b0;
         bub_idx_q <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         bubble_q <= 1'b0;
         if (abort_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            i_q     <= '0;
            r_q     <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start_i) begin
                     if (k_len_i != 4'd0) begin
                        k_q     <= k_len_i;
                        cnt_q   <= '0;
                        state_q <= LOAD_W;
                     end else begin
                        err_q <= 1'b1;
                     end
                  end
               end
               LOAD_W: begin
                  if (!host_wr_i) begin
                     if (cnt_q == 8'(NumW - 1)) begin
                        cnt_q   <= '0;
                        i_q     <= '0;
                        r_q     <= '0;
                        state_q <= STREAM;
                     end else begin
                        cnt_q <= cnt_q + 8'd1;
                     end
                  end
               end
               STREAM: begin
                  if (!host_wr_i) begin
                     if (r_q == 4'(ROWS - 1)) begin
                        r_q <= '0;
                        if (i_q == k_q - 4'd1) begin
                           cnt_q   <= '0;
                           state_q <= DRAIN;
                        end else begin
                           i_q <= i_q + 4'd1;
                        end
                     end else begin
                        r_q <= r_q + 4'd1;
                     end
                  end
               end
               DRAIN: begin
                  // First DRAIN cycle overlaps the last read return; bubbles surface one cycle
                  // after issue, just like read data.
                  if (cnt_q == 8'(NumBub)) begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     bubble_q  <= 1'b1;
                     bub_idx_q <= IDX_W'(r_q);
                     cnt_q     <= cnt_q + 8'd1;
                     r_q       <= (r_q == 4'(ROWS - 1)) ? 4'd0 : r_q + 4'd1;
                  end
               end
               DONE:    state_q <= IDLE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   systolic_rd_tag u_rd_tag (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (abort_i),
      .kind_i (tag_kind_d),
      .idx_i  (tag_idx_d),
      .kind_o (tag_kind_q),
      .idx_o  (tag_idx_q)
   );

   assign tag_valid   = (tag_kind_q != TAG_NONE);
   assign arr_wload_o = (tag_kind_q == TAG_W);
   assign arr_act_o   = (tag_kind_q == TAG_ACT) | bubble_q;
   assign arr_idx_o   = tag_valid ? tag_idx_q : (bubble_q ? bub_idx_q : '0);
   assign arr_data_o  = tag_valid ? mem_rdata_i : '0;
   assign busy_o      = (state_q != IDLE);
   assign done_o      = done_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed, table-driven bench for systolic_sequencer with a synchronous-read register-file model.
module tb_systolic_sequencer;

   typedef struct packed {
      logic       rd;
      logic [6:0] addr;
      logic       wl;
      logic       act;
      logic [3:0] idx;
      logic [7:0] data;
      logic       busy;
      logic       done;
      logic       err;
   } out_t;

   typedef struct {
      logic hw;
      out_t exp;
   } vec_t;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       abort;
   logic [3:0] k_len;
   logic       host_wr;
   logic       mem_rd_en;
   logic [6:0] mem_addr;
   logic [7:0] mem_rdata;
   logic       arr_wload;
   logic       arr_act;
   logic [3:0] arr_idx;
   logic [7:0] arr_data;
   logic       busy;
   logic       done;
   logic       err;

   logic [7:0] mem [0:127];
   out_t       cap [0:39];
   vec_t       tbl [0:16];
   int         errors;
   int         checks;

   systolic_sequencer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (start),
      .abort_i     (abort),
      .k_len_i     (k_len),
      .host_wr_i   (host_wr),
      .mem_rd_en_o (mem_rd_en),
      .mem_addr_o  (mem_addr),
      .mem_rdata_i (mem_rdata),
      .arr_wload_o (arr_wload),
      .arr_act_o   (arr_act),
      .arr_idx_o   (arr_idx),
      .arr_data_o  (arr_data),
      .busy_o      (busy),
      .done_o      (done),
      .err_o       (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial mem_rdata = 8'd0;
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= mem[mem_addr];
   end

   function automatic out_t sample_now();
      out_t o;
      o.rd   = mem_rd_en;
      o.addr = mem_addr;
      o.wl   = arr_wload;
      o.act  = arr_act;
      o.idx  = arr_idx;
      o.data = arr_data;
      o.busy = busy;
      o.done = done;
      o.err  = err;
      return o;
   endfunction

   function automatic out_t mk(input int rd, input int addr, input int wl, input int act,
                               input int idx, input int data, input int bsy, input int dn,
                               input int er);
      out_t o;
      o.rd   = rd[0];
      o.addr = 7'(addr);
      o.wl   = wl[0];
      o.act  = act[0];
      o.idx  = 4'(idx);
      o.data = 8'(data);
      o.busy = bsy[0];
      o.done = dn[0];
      o.err  = er[0];
      return o;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Drives cycle c (cycle 0 carries start), samples mid-cycle. Entered and left at posedge+1.
   task automatic run(input int ncyc, input logic [3:0] k, input logic [39:0] hw,
                      input int ab_cyc, input int rs_cyc, input logic [3:0] rs_k);
      for (int c = 0; c < ncyc; c++) begin
         start   = (c == 0) || (c == rs_cyc);
         k_len   = (c == 0) ? k : ((c == rs_cyc) ? rs_k : 4'd0);
         host_wr = hw[c];
         abort   = (c == ab_cyc);
         @(negedge clk);
         cap[c] = sample_now();
         @(posedge clk);
         #1;
      end
      start   = 1'b0;
      k_len   = 4'd0;
      host_wr = 1'b0;
      abort   = 1'b0;
   endtask

   task automatic run_table(input string tag);
      logic [39:0] hwm;
      hwm = '0;
      for (int c = 0; c < 17; c++) hwm[c] = tbl[c].hw;
      run(17, 4'd3, hwm, -1, -1, 4'd0);
      for (int c = 0; c < 17; c++)
         check($sformatf("%s cyc%0d", tag, c), 32'(cap[c]), 32'(tbl[c].exp));
   endtask

   function automatic int first_done(input int n);
      for (int c = 0; c < n; c++) if (cap[c].done) return c;
      return -1;
   endfunction

   initial begin
      logic [39:0] hwm;
      int          n;
      int          exp_addr [10];
      int          exp_data [13];
      int          got_list [$];

      errors  = 0;
      checks  = 0;
      rst_n   = 1'b0;
      start   = 1'b0;
      abort   = 1'b0;
      k_len   = 4'd0;
      host_wr = 1'b0;
      for (int a = 0; a < 128; a++) mem[a] = 8'd0;
      for (int a = 0; a < 4; a++) mem[a] = 8'(a + 1);
      for (int a = 0; a < 6; a++) mem[16 + a] = 8'(10 + a);

      tbl[0]  = '{1'b0, mk(0,  0, 0, 0, 0,  0, 0, 0, 0)};
      tbl[1]  = '{1'b0, mk(1,  0, 0, 0, 0,  0, 1, 0, 0)};
      tbl[2]  = '{1'b0, mk(1,  1, 1, 0, 0,  1, 1, 0, 0)};
      tbl[3]  = '{1'b0, mk(1,  2, 1, 0, 1,  2, 1, 0, 0)};
      tbl[4]  = '{1'b0, mk(1,  3, 1, 0, 2,  3, 1, 0, 0)};
      tbl[5]  = '{1'b0, mk(1, 16, 1, 0, 3,  4, 1, 0, 0)};
      tbl[6]  = '{1'b0, mk(1, 17, 0, 1, 0, 10, 1, 0, 0)};
      tbl[7]  = '{1'b0, mk(1, 18, 0, 1, 1, 11, 1, 0, 0)};
      tbl[8]  = '{1'b0, mk(1, 19, 0, 1, 0, 12, 1, 0, 0)};
      tbl[9]  = '{1'b0, mk(1, 20, 0, 1, 1, 13, 1, 0, 0)};
      tbl[10] = '{1'b0, mk(1, 21, 0, 1, 0, 14, 1, 0, 0)};
      tbl[11] = '{1'b0, mk(0,  0, 0, 1, 1, 15, 1, 0, 0)};
      tbl[12] = '{1'b0, mk(0,  0, 0, 1, 0,  0, 1, 0, 0)};
      tbl[13] = '{1'b0, mk(0,  0, 0, 1, 1,  0, 1, 0, 0)};
      tbl[14] = '{1'b0, mk(0,  0, 0, 1, 0,  0, 1, 0, 0)};
      tbl[15] = '{1'b0, mk(0,  0, 0, 0, 0,  0, 1, 1, 0)};
      tbl[16] = '{1'b0, mk(0,  0, 0, 0, 0,  0, 0, 0, 0)};

      repeat (3) @(posedge clk);
      #1;
      check("reset outputs", 32'(sample_now()), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_table("base");

      // Host stalls in cycles 3 and 7.
      hwm = '0;
      hwm[3] = 1'b1;
      hwm[7] = 1'b1;
      run(20, 4'd3, hwm, -1, -1, 4'd0);
      exp_addr = '{0, 1, 2, 3, 16, 17, 18, 19, 20, 21};
      exp_data = '{1, 2, 3, 4, 10, 11, 12, 13, 14, 15, 0, 0, 0};
      check("stall rd_en c3", 32'(cap[3].rd), 32'd0);
      check("stall rd_en c7", 32'(cap[7].rd), 32'd0);
      got_list.delete();
      for (int c = 0; c < 20; c++) if (cap[c].rd) got_list.push_back(int'(cap[c].addr));
      check("stall read count", 32'(got_list.size()), 32'd10);
      n = (got_list.size() < 10) ? got_list.size() : 10;
      for (int j = 0; j < n; j++)
         check($sformatf("stall addr%0d", j), 32'(got_list[j]), 32'(exp_addr[j]));
      got_list.delete();
      for (int c = 0; c < 20; c++)
         if (cap[c].wl || cap[c].act) got_list.push_back(int'(cap[c].data));
      check("stall arr count", 32'(got_list.size()), 32'd13);
      n = (got_list.size() < 13) ? got_list.size() : 13;
      for (int j = 0; j < n; j++)
         check($sformatf("stall data%0d", j), 32'(got_list[j]), 32'(exp_data[j]));
      check("stall done cycle", 32'(first_done(20)), 32'd17);
      check("stall busy c17", 32'(cap[17].busy), 32'd1);
      check("stall busy c18", 32'(cap[18].busy), 32'd0);

      // k_len == 0 rejected.
      run(4, 4'd0, '0, -1, -1, 4'd0);
      check("k0 err c1", 32'(cap[1].err), 32'd1);
      check("k0 err c2", 32'(cap[2].err), 32'd0);
      n = 0;
      for (int c = 0; c < 4; c++) n += int'(cap[c].busy) + int'(cap[c].rd);
      check("k0 busy/rd count", 32'(n), 32'd0);

      // Abort in cycle 7, then a clean run.
      run(12, 4'd3, '0, 7, -1, 4'd0);
      check("abort busy c7", 32'(cap[7].busy), 32'd1);
      check("abort busy c8", 32'(cap[8].busy), 32'd0);
      n = 0;
      for (int c = 8; c < 12; c++) n += int'(cap[c].wl) + int'(cap[c].act);
      check("abort arr after c7", 32'(n), 32'd0);
      check("abort no done", 32'(first_done(12)), 32'hffff_ffff);
      run_table("after abort");

      // Restart request in cycle 4 is ignored.
      run(17, 4'd3, '0, -1, 4, 4'd5);
      for (int c = 0; c < 17; c++)
         check($sformatf("restart cyc%0d", c), 32'(cap[c]), 32'(tbl[c].exp));

      // Async reset in cycle 9.
      run(9, 4'd3, '0, -1, -1, 4'd0);
      check("rst pre busy", 32'(cap[8].busy), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst async outputs", 32'(sample_now()), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run(14, 4'd1, '0, -1, -1, 4'd0);
      check("post rst done cycle", 32'(first_done(14)), 32'd11);
      check("post rst act c6", 32'({cap[6].act, cap[6].data}), 32'h10a);
      check("post rst busy c12", 32'(cap[12].busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
